// File: rtl/fn1_pkg.sv
// fn1 multiply-accumulate slice: shared types and defaults.
// Holds accumulator state encoding and tag layout.
package fn1_pkg;

    localparam int LAT_DEF = 4;
    localparam int DW_DEF  = 16;
    localparam int CW_DEF  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic vld;
        logic last;
    } tag_t;

endpackage

// File: rtl/fn1_tag_delay.sv
// fn1 tag delay line: depth-stage shift register.
// Advances only when en is high so it tracks the multiplier pipe.
module fn1_tag_delay #(
    parameter int depth = 4,
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [width-1:0] pipe [depth];

    // shift tags one stage per enabled cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) begin
                pipe[i] <= '0;
            end
        end else if (en) begin
            pipe[0] <= din;
            for (int i = 1; i < depth; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[depth-1];

endmodule

// File: rtl/fn1_mul_acc_stage.sv
// fn1 accumulate stage: sums signed products of an external
// multiplier into groups delimited by in_last, with backpressure.
module fn1_mul_acc_stage
    import fn1_pkg::*;
#(
    parameter int LAT = LAT_DEF,
    parameter int DW  = DW_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_vld,
    input  logic                 in_last,
    output logic                 in_rdy,
    output logic                 mul_ce,
    input  logic signed [DW-1:0] mul_dout,
    output logic                 sum_vld,
    input  logic                 sum_rdy,
    output logic signed [DW-1:0] sum_data,
    output logic        [CW-1:0] sum_cnt
);

    acc_state_e           state, state_d;
    logic signed [DW-1:0] acc, acc_d, acc_next;
    logic        [CW-1:0] cnt, cnt_d, cnt_inc;
    logic                 sum_vld_d;
    logic signed [DW-1:0] sum_data_d;
    logic        [CW-1:0] sum_cnt_d;
    logic        [1:0]    tail_bits;
    tag_t                 tail;

    assign mul_ce = (!sum_vld || sum_rdy) && !reset;
    assign in_rdy = mul_ce;

    fn1_tag_delay #(
        .depth(LAT),
        .width(2)
    ) u_tags (
        .clk  (clk),
        .reset(reset),
        .en   (mul_ce),
        .din  ({in_vld, in_vld && in_last}),
        .dout (tail_bits)
    );

    assign tail = tag_t'(tail_bits);

    // next accumulator, count and result register contents
    always_comb begin
        state_d    = state;
        acc_d      = acc;
        cnt_d      = cnt;
        sum_vld_d  = sum_vld;
        sum_data_d = sum_data;
        sum_cnt_d  = sum_cnt;
        cnt_inc    = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
        acc_next   = mul_dout;
        unique case (state)
            EMPTY: acc_next = mul_dout;
            ACCUM: acc_next = acc + mul_dout;
            default: acc_next = mul_dout;
        endcase
        if (sum_vld && sum_rdy) begin
            sum_vld_d = 1'b0;
        end
        if (mul_ce && tail.vld) begin
            if (tail.last) begin
                sum_vld_d  = 1'b1;
                sum_data_d = acc_next;
                sum_cnt_d  = cnt_inc;
                acc_d      = '0;
                cnt_d      = '0;
                state_d    = EMPTY;
            end else begin
                acc_d   = acc_next;
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end
        end
    end

    // register FSM, accumulator and completed-sum outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            acc      <= '0;
            cnt      <= '0;
            sum_vld  <= 1'b0;
            sum_data <= '0;
            sum_cnt  <= '0;
        end else begin
            state    <= state_d;
            acc      <= acc_d;
            cnt      <= cnt_d;
            sum_vld  <= sum_vld_d;
            sum_data <= sum_data_d;
            sum_cnt  <= sum_cnt_d;
        end
    end

endmodule
